// File: rtl/ip_pkg.sv
// Shared IPv4/UDP constants, FSM state and header bundle.
// Used by the UDP/IP encoder and the matching decoder.
package ip_pkg;

  localparam logic [3:0] IPV4_VERSION  = 4'd4;
  localparam logic [3:0] IPV4_IHL      = 4'd5;
  localparam logic [7:0] PROTO_UDP     = 8'd17;
  localparam logic [7:0] PROTO_TCP     = 8'd6;
  localparam int         IP_HDR_BYTES  = 20;
  localparam int         UDP_HDR_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    HDR,
    PAY,
    ERR
  } state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] len;
    logic [15:0] id;
    logic [7:0]  tos;
    logic [7:0]  ttl;
  } tx_hdr_t;

endpackage

// File: rtl/ip_hdr_csum.sv
// Ones-complement checksum over a 20-byte IPv4 header.
// The checksum field inside hdr must be zero when generating.
module ip_hdr_csum (
  input  logic [159:0] hdr,
  output logic [15:0]  csum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [16:0] fold2;

  // Sum ten words, fold the carries back in twice, then invert
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      sum = sum + 20'(hdr[159-16*i -: 16]);
    end
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = 17'(fold1[15:0]) + 17'(fold1[16]);
    csum  = ~fold2[15:0];
  end

endmodule

// File: rtl/udp_ip_encoder.sv
// IPv4 + UDP transmit encoder, big-endian 32-bit word stream.
// IP_ID_AUTO_EN: IPv4 identification from an internal counter.
module udp_ip_encoder
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL_DEFAULT = 8'd64,
  parameter logic [15:0] MAX_LEN     = 16'd65507
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dest_port,
  input  logic [15:0] len_data,
  input  logic [7:0]  type_of_ser,
  input  logic [7:0]  time_to_live,
  input  logic [15:0] identification,
  input  logic [31:0] data_in,
  output logic        rd_en,
  output logic [31:0] data_out,
  output logic        wr_en,
  output logic [15:0] len_out,
  output logic        busy,
  output logic        fin,
  output logic        err
);

  state_t      state, state_nx;
  tx_hdr_t     hdr_q;
  logic [2:0]  idx;
  logic [15:0] w_cnt;
  logic [15:0] csum_q;
  logic [15:0] csum;
  logic [31:0] pay_q;
  logic [15:0] id_sel;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [15:0] n_words;
  logic [15:0] rd_idx;
  logic [31:0] tail_mask;
  logic [31:0] rd_mask;
  logic        last_hdr;
  logic        last_pay;

`ifdef IP_ID_AUTO_EN
  logic [15:0] id_cnt;

  // Packet ID counter advances once per completed packet
  always_ff @(posedge clk) begin
    if (reset) begin
      id_cnt <= '0;
    end else if (fin) begin
      id_cnt <= id_cnt + 16'd1;
    end
  end

  assign id_sel = id_cnt;
`else
  assign id_sel = identification;
`endif

  assign tot_len = hdr_q.len + 16'(IP_HDR_BYTES + UDP_HDR_BYTES);
  assign udp_len = hdr_q.len + 16'(UDP_HDR_BYTES);
  assign n_words = 16'((17'(hdr_q.len) + 17'd3) >> 2);
  assign last_hdr = (state == HDR) && (idx == 3'd6);
  assign last_pay = (state == PAY) && (w_cnt == n_words - 16'd1);
  assign rd_idx = (state == PAY) ? w_cnt + 16'd1 : 16'd0;

  ip_hdr_csum u_csum (
    .hdr  ({IPV4_VERSION, IPV4_IHL, hdr_q.tos, tot_len,
            hdr_q.id, 3'b010, 13'd0,
            hdr_q.ttl, PROTO_UDP, 16'h0000,
            hdr_q.src_ip, hdr_q.dest_ip}),
    .csum (csum)
  );

  // Keep only the valid leading bytes of the final payload word
  always_comb begin
    tail_mask = '1;
    unique case (hdr_q.len[1:0])
      2'd1:    tail_mask = 32'hFF00_0000;
      2'd2:    tail_mask = 32'hFFFF_0000;
      2'd3:    tail_mask = 32'hFFFF_FF00;
      default: tail_mask = '1;
    endcase
    rd_mask = (rd_idx == n_words - 16'd1) ? tail_mask : '1;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len_data > MAX_LEN) ? ERR : CSUM;
        end
      end
      CSUM: state_nx = HDR;
      HDR: begin
        if (idx == 3'd6) begin
          state_nx = (n_words == 16'd0) ? IDLE : PAY;
        end
      end
      PAY: begin
        if (last_pay) begin
          state_nx = IDLE;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status and strobe outputs, all decoded from the current state
  always_comb begin
    busy    = (state != IDLE);
    err     = (state == ERR);
    wr_en   = (state == HDR) || (state == PAY);
    fin     = (last_hdr && (n_words == 16'd0)) || last_pay;
    rd_en   = (last_hdr && (n_words != 16'd0)) ||
              ((state == PAY) && !last_pay);
    len_out = '0;
    if ((state == CSUM) || (state == HDR) || (state == PAY)) begin
      len_out = tot_len;
    end
  end

  // Output word select: header words, then registered payload
  always_comb begin
    data_out = '0;
    unique case (state)
      HDR: begin
        case (idx)
          3'd0: data_out = {IPV4_VERSION, IPV4_IHL, hdr_q.tos, tot_len};
          3'd1: data_out = {hdr_q.id, 3'b010, 13'd0};
          3'd2: data_out = {hdr_q.ttl, PROTO_UDP, csum_q};
          3'd3: data_out = hdr_q.src_ip;
          3'd4: data_out = hdr_q.dest_ip;
          3'd5: data_out = {hdr_q.src_port, hdr_q.dest_port};
          3'd6: data_out = {udp_len, 16'h0000};
          default: data_out = '0;
        endcase
      end
      PAY:     data_out = pay_q;
      default: data_out = '0;
    endcase
  end

  // State, request latch, checksum and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hdr_q  <= '0;
      idx    <= '0;
      w_cnt  <= '0;
      csum_q <= '0;
      pay_q  <= '0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && start) begin
        hdr_q.src_ip    <= src_ip;
        hdr_q.dest_ip   <= dest_ip;
        hdr_q.src_port  <= src_port;
        hdr_q.dest_port <= dest_port;
        hdr_q.len       <= len_data;
        hdr_q.id        <= id_sel;
        hdr_q.tos       <= type_of_ser;
        hdr_q.ttl       <= (time_to_live == 8'd0) ?
                           TTL_DEFAULT : time_to_live;
      end
      if (state == CSUM) begin
        csum_q <= csum;
      end
      idx   <= (state == HDR) ? idx + 3'd1 : 3'd0;
      w_cnt <= (state == PAY) ? w_cnt + 16'd1 : 16'd0;
      if (rd_en) begin
        pay_q <= data_in & rd_mask;
      end
    end
  end

endmodule

// File: tb/tb_udp_ip_encoder.sv
// Self-checking bench for udp_ip_encoder.
// Build with +define+IP_ID_AUTO_EN to cover the auto-ID feature.
module tb_udp_ip_encoder;

`ifdef IP_ID_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_ip = '0, dest_ip = '0, data_in = '0;
  logic [15:0] src_port = '0, dest_port = '0;
  logic [15:0] len_data = '0, identification = '0;
  logic [7:0]  type_of_ser = '0, time_to_live = '0;
  logic        rd_en, wr_en, busy, fin, err;
  logic [31:0] data_out;
  logic [15:0] len_out;

  udp_ip_encoder dut (
    .clk(clk), .reset(reset), .start(start),
    .src_ip(src_ip), .dest_ip(dest_ip),
    .src_port(src_port), .dest_port(dest_port),
    .len_data(len_data), .type_of_ser(type_of_ser),
    .time_to_live(time_to_live),
    .identification(identification),
    .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .wr_en(wr_en),
    .len_out(len_out), .busy(busy),
    .fin(fin), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] f_src, f_dst;
  logic [15:0] f_sp, f_dp, f_len, f_id;
  logic [7:0]  f_tos, f_ttl;
  logic [15:0] model_id = '0;
  logic [31:0] pay_src[$];
  logic [31:0] exp_w[$];

  logic [31:0] got_w[$];
  int          got_c[$];
  int          rd_c[$];
  int          fin_c, fin_n, err_c, end_c, pops, first_bad;
  bit          timeout, snap_zero;
  logic [15:0] len1;

  // Reference packet built byte-wise from the protocol rules
  task automatic model_pkt();
    logic [15:0] w[10];
    logic [7:0]  ttl;
    logic [15:0] id, cs;
    logic [31:0] pw;
    int          s, n;
    ttl = (f_ttl == 8'd0) ? 8'd64 : f_ttl;
    id  = AUTO ? model_id : f_id;
    w[0] = {8'h45, f_tos};
    w[1] = f_len + 16'd28;
    w[2] = id;
    w[3] = 16'h4000;
    w[4] = {ttl, 8'd17};
    w[5] = 16'h0000;
    w[6] = f_src[31:16];
    w[7] = f_src[15:0];
    w[8] = f_dst[31:16];
    w[9] = f_dst[15:0];
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(w[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
    cs = ~s[15:0];
    exp_w.delete();
    exp_w.push_back({w[0], w[1]});
    exp_w.push_back({w[2], w[3]});
    exp_w.push_back({w[4], cs});
    exp_w.push_back(f_src);
    exp_w.push_back(f_dst);
    exp_w.push_back({f_sp, f_dp});
    exp_w.push_back({f_len + 16'd8, 16'h0000});
    n = (int'(f_len) + 3) / 4;
    for (int i = 0; i < n; i++) begin
      pw = pay_src[i];
      for (int j = 0; j < 4; j++)
        if (i * 4 + j >= int'(f_len)) pw[31-8*j -: 8] = 8'h00;
      exp_w.push_back(pw);
    end
  endtask

  task automatic rand_fields(input logic [15:0] len);
    f_src = $urandom;
    f_dst = $urandom;
    f_sp  = 16'($urandom);
    f_dp  = 16'($urandom);
    f_id  = 16'($urandom);
    f_tos = 8'($urandom);
    f_ttl = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    f_len = len;
    pay_src.delete();
    for (int i = 0; i < (int'(len) + 3) / 4; i++)
      pay_src.push_back($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_id = '0;
  endtask

  // Drive one request and capture everything the DUT emits
  task automatic run_pkt(input int s1, input int s2, input int rst_at);
    int maxc;
    got_w.delete();
    got_c.delete();
    rd_c.delete();
    fin_c = -1; fin_n = 0; err_c = -1; end_c = -1;
    pops = 0; timeout = 0; snap_zero = 0; len1 = '0;
    maxc = 24 + pay_src.size();
    @(negedge clk);
    src_ip = f_src; dest_ip = f_dst;
    src_port = f_sp; dest_port = f_dp;
    len_data = f_len; identification = f_id;
    type_of_ser = f_tos; time_to_live = f_ttl;
    start = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (wr_en) begin
        got_w.push_back(data_out);
        got_c.push_back(c);
      end
      if (rd_en) begin
        rd_c.push_back(c);
        data_in = (pops < pay_src.size()) ? pay_src[pops] : $urandom;
        pops++;
      end
      if (fin) begin
        fin_n++;
        if (fin_c < 0) fin_c = c;
      end
      if (err) err_c = c;
      if (c == 1) len1 = len_out;
      if (!busy) begin
        end_c = c;
        snap_zero = !(wr_en | rd_en | fin | err) &&
                    (len_out == 16'h0) && (data_out == 32'h0);
        break;
      end
      start = (c == s1) || (c == s2);
      reset = (c == rst_at);
      if (c == 1) begin
        src_ip = $urandom; dest_ip = $urandom;
        src_port = 16'($urandom); len_data = 16'($urandom);
        identification = 16'($urandom);
        time_to_live = 8'($urandom);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    if (end_c < 0) timeout = 1;
    if (fin_n > 0) model_id++;
    if (rst_at > 0) model_id = '0;
  endtask

  function automatic int stream_errs();
    int bad = 0;
    first_bad = -1;
    if (got_w.size() != exp_w.size()) return 1000000;
    foreach (exp_w[i]) begin
      if (got_w[i] !== exp_w[i] || got_c[i] != 2 + i) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return bad;
  endfunction

  function automatic int rd_errs();
    int bad = 0;
    if (rd_c.size() != pay_src.size()) return 1000000;
    foreach (rd_c[k]) if (rd_c[k] != 8 + k) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({wr_en, rd_en, fin, err, busy} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000",
               {wr_en, rd_en, fin, err, busy});
    else n_pass++;
    n_chk++;
    if (data_out !== 32'h0 || len_out !== 16'h0)
      $display("FAIL reset_data got %h/%h want 0/0", data_out, len_out);
    else n_pass++;
  endtask

  task automatic test_basic();
    int e;
    logic [31:0] lit[9];
    lit = '{32'h45000020, 32'h1C464000, 32'h40119C6E,
            32'hC0A80001, 32'hC0A800C7, 32'h12340050,
            32'h000C0000, 32'hAABBCCDD, 32'h0};
    f_src = 32'hC0A80001; f_dst = 32'hC0A800C7;
    f_tos = 8'h00; f_ttl = 8'd64; f_id = 16'h1C46;
    f_sp = 16'h1234; f_dp = 16'h0050; f_len = 16'd4;
    pay_src = '{32'hAABBCCDD};
    model_pkt();
    run_pkt(-1, -1, -1);
    e = stream_errs();
    n_chk++;
    if (e != 0)
      $display("FAIL basic_words errs %0d first %0d", e, first_bad);
    else n_pass++;
    n_chk++;
    if (got_w.size() != 8)
      $display("FAIL basic_count got %0d want 8", got_w.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        if (AUTO && (i == 1 || i == 2)) continue;
        n_chk++;
        if (got_w[i] !== lit[i])
          $display("FAIL basic_w%0d got %h want %h", i, got_w[i], lit[i]);
        else n_pass++;
      end
    end
    n_chk++;
    if (fin_c != 9 || fin_n != 1)
      $display("FAIL basic_fin got c%0d n%0d want c9 n1", fin_c, fin_n);
    else n_pass++;
    n_chk++;
    if (len1 !== 16'h0020)
      $display("FAIL basic_len_out got %h want 0020", len1);
    else n_pass++;
    n_chk++;
    if (rd_errs() != 0 || end_c != 10)
      $display("FAIL basic_rd rd %0d end %0d want 1 @8 end 10",
               rd_c.size(), end_c);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    rand_fields(16'd0);
    model_pkt();
    run_pkt(-1, -1, -1);
    n_chk++;
    if (stream_errs() != 0 || got_w.size() != 7)
      $display("FAIL zero_words got %0d words want 7", got_w.size());
    else n_pass++;
    n_chk++;
    if (got_w.size() < 7 || got_w[6] !== 32'h00080000)
      $display("FAIL zero_u1 got %h want 00080000",
               got_w.size() >= 7 ? got_w[6] : 32'hx);
    else n_pass++;
    n_chk++;
    if (fin_c != 8 || rd_c.size() != 0 || end_c != 9)
      $display("FAIL zero_fin got fin%0d rd%0d end%0d want 8 0 9",
               fin_c, rd_c.size(), end_c);
    else n_pass++;
  endtask

  task automatic test_len5();
    logic [31:0] want;
    rand_fields(16'd5);
    model_pkt();
    run_pkt(-1, -1, -1);
    want = {pay_src[1][31:24], 24'h0};
    n_chk++;
    if (stream_errs() != 0)
      $display("FAIL len5_words errs %0d first %0d", stream_errs(), first_bad);
    else n_pass++;
    n_chk++;
    if (got_w.size() != 9 || got_w[8] !== want)
      $display("FAIL len5_tail got %h want %h",
               got_w.size() == 9 ? got_w[8] : 32'hx, want);
    else n_pass++;
    n_chk++;
    if (fin_c != 10 || rd_errs() != 0)
      $display("FAIL len5_fin got fin%0d rd%0d want 10 2", fin_c, rd_c.size());
    else n_pass++;
  endtask

  task automatic test_err();
    int e;
    rand_fields(16'd0);
    f_len = 16'd65508;
    run_pkt(-1, -1, -1);
    n_chk++;
    if (err_c != 1 || got_w.size() != 0 || fin_n != 0)
      $display("FAIL err_pulse got err%0d wr%0d fin%0d want 1 0 0",
               err_c, got_w.size(), fin_n);
    else n_pass++;
    n_chk++;
    if (end_c < 0 || end_c > 2)
      $display("FAIL err_busy got end %0d want <=2", end_c);
    else n_pass++;
    rand_fields(16'd65507);
    model_pkt();
    run_pkt(-1, -1, -1);
    e = stream_errs();
    n_chk++;
    if (e != 0 || err_c != -1)
      $display("FAIL max_words errs %0d first %0d err %0d", e, first_bad, err_c);
    else n_pass++;
    n_chk++;
    if (fin_c != 8 + 16377 || rd_errs() != 0)
      $display("FAIL max_fin got %0d want %0d", fin_c, 8 + 16377);
    else n_pass++;
  endtask

  task automatic test_random();
    int len, e;
    for (int p = 0; p < 10; p++) begin
      len = (p < 4) ? p : $urandom_range(0, 48);
      rand_fields(16'(len));
      model_pkt();
      run_pkt(-1, -1, -1);
      e = stream_errs();
      n_chk++;
      if (e != 0 || timeout)
        $display("FAIL rand%0d_words len %0d errs %0d first %0d",
                 p, len, e, first_bad);
      else n_pass++;
      n_chk++;
      if (fin_c != 8 + (len + 3) / 4 || fin_n != 1)
        $display("FAIL rand%0d_fin got c%0d n%0d want c%0d n1",
                 p, fin_c, fin_n, 8 + (len + 3) / 4);
      else n_pass++;
      n_chk++;
      if (rd_errs() != 0 || len1 !== 16'(len + 28))
        $display("FAIL rand%0d_rd rd %0d len_out %h want %0d %h",
                 p, rd_c.size(), len1, pay_src.size(), 16'(len + 28));
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    int idle_busy = 0;
    rand_fields(16'd4);
    model_pkt();
    run_pkt(3, 8, -1);
    n_chk++;
    if (stream_errs() != 0 || fin_c != 9 || end_c != 10)
      $display("FAIL ign_pkt got fin%0d end%0d want 9 10", fin_c, end_c);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (busy || wr_en) idle_busy++;
    end
    n_chk++;
    if (idle_busy != 0)
      $display("FAIL ign_queued got %0d busy cycles want 0", idle_busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    rand_fields(16'd8);
    run_pkt(-1, -1, 5);
    n_chk++;
    if (end_c != 6 || !snap_zero || fin_n != 0)
      $display("FAIL rst_mid got end%0d zero%0d fin%0d want 6 1 0",
               end_c, snap_zero, fin_n);
    else n_pass++;
    repeat (4) begin
      @(negedge clk);
      if (fin || wr_en || busy) stray++;
    end
    n_chk++;
    if (stray != 0)
      $display("FAIL rst_quiet got %0d active cycles want 0", stray);
    else n_pass++;
    rand_fields(16'd7);
    model_pkt();
    run_pkt(-1, -1, -1);
    n_chk++;
    if (stream_errs() != 0 || fin_c != 10)
      $display("FAIL rst_after errs %0d fin %0d want 0 10",
               stream_errs(), fin_c);
    else n_pass++;
  endtask

  task automatic test_auto_id();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      rand_fields(16'($urandom_range(0, 12)));
      model_pkt();
      run_pkt(-1, -1, -1);
      n_chk++;
      if (got_w.size() < 2 || got_w[1][31:16] !== 16'(p))
        $display("FAIL auto_id%0d got %h want %h", p,
                 got_w.size() >= 2 ? got_w[1][31:16] : 16'hx, 16'(p));
      else n_pass++;
      n_chk++;
      if (stream_errs() != 0)
        $display("FAIL auto_words%0d errs %0d", p, stream_errs());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len5();
    test_err();
    test_random();
    test_ignore_start();
    test_mid_reset();
    if (AUTO) test_auto_id();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
